// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx load/store unit: op encodings, FSM states,
// access-size strobe masks and alignment helpers.
package ysyx_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_WU  = 3'b110;
  localparam logic [2:0] F3_BAD = 3'b111;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_WB   = 2'd3
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return MASK_B;
      2'd1:    return MASK_H;
      2'd2:    return MASK_W;
      2'd3:    return MASK_D;
      default: return MASK_D;
    endcase
  endfunction

  // Byte-offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      2'd3:    return 3'd7;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Combinational lane logic: store data/strobe shifting and load data
// shift plus sign/zero extension. Lanes past the XLEN word are dropped.
module ysyx_lsu_align
  import ysyx_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]                    op,
  input  logic [$clog2(XLEN/8)-1:0]     off,
  input  logic [XLEN-1:0]               wdata,
  input  logic [XLEN-1:0]               rdata,
  output logic [7:0]                    wstrb,
  output logic [XLEN-1:0]               wdata_sh,
  output logic [XLEN-1:0]               ld_data
);

  localparam int         OFF_W = $clog2(XLEN/8);
  localparam logic [7:0] LANES = (XLEN == 64) ? 8'hFF : 8'h0F;

  logic [OFF_W+2:0] sh_amt_s;
  logic [XLEN-1:0]  ld_sh_s;
  logic [XLEN-1:0]  low_mask_s;
  logic [XLEN-1:0]  sign_pos_s;
  logic [6:0]       nbits_s;
  logic             sign_s;

  // Lane shifting, strobe truncation and load extension.
  always_comb begin
    sh_amt_s = {off, 3'b000};
    if (op[3]) begin
      wstrb = (size_mask(op[1:0]) << off) & LANES;
    end else begin
      wstrb = 8'h00;
    end
    wdata_sh = wdata << sh_amt_s;
    ld_sh_s  = rdata >> sh_amt_s;
    case (op[1:0])
      2'd0:    nbits_s = 7'd8;
      2'd1:    nbits_s = 7'd16;
      2'd2:    nbits_s = 7'd32;
      default: nbits_s = 7'd64;
    endcase
    // Shifts by >= XLEN yield zero, so full-width accesses keep every bit.
    low_mask_s = ~({XLEN{1'b1}} << nbits_s);
    sign_pos_s = {{(XLEN-1){1'b0}}, 1'b1} << (nbits_s - 7'd1);
    sign_s     = ~op[2] & (|(ld_sh_s & sign_pos_s));
    ld_data    = (ld_sh_s & low_mask_s) | ({XLEN{sign_s}} & ~low_mask_s);
  end

endmodule

// File: rtl/ysyx_lsu.sv
// ysyx load/store unit: IDLE -> REQ -> WAIT -> WB request sequencer.
// Define YSYX_LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module ysyx_lsu
  import ysyx_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ID_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [ID_W-1:0] req_rd,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic            mem_req_we,
  output logic [XLEN-1:0] mem_req_addr,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wstrb,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_rdata,
  input  logic            mem_rsp_err,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [XLEN-1:0] wb_data,
  output logic [ID_W-1:0] wb_rd,
  output logic            wb_err
);

  localparam int OFF_W = $clog2(XLEN/8);

  lsu_state_e      state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [ID_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            wb_err_q, wb_err_d;

  logic [2:0]      f3_s;
  logic            illegal_s;
  logic            misalign_s;
  logic            fault_s;
  logic [XLEN-1:0] ld_data_s;

  ysyx_lsu_align #(.XLEN(XLEN)) u_align (
    .op       (op_q),
    .off      (addr_q[OFF_W-1:0]),
    .wdata    (wdata_q),
    .rdata    (mem_rsp_rdata),
    .wstrb    (mem_req_wstrb),
    .wdata_sh (mem_req_wdata),
    .ld_data  (ld_data_s)
  );

  // Request legality: encoding holes, width unsupported at this XLEN, optional alignment trap.
  always_comb begin
    f3_s      = req_op[2:0];
    illegal_s = (f3_s == F3_BAD) || (req_op[3] && f3_s[2]) ||
                ((XLEN == 32) && ((f3_s == F3_D) || (f3_s == F3_WU)));
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    misalign_s = ((3'(req_addr[OFF_W-1:0]) & align_mask(req_op[1:0])) != 3'b000);
`else
    misalign_s = 1'b0;
`endif
    fault_s = illegal_s || misalign_s;
  end

  // Next-state and registered-field update.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    wb_data_d = wb_data_q;
    wb_err_d  = wb_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d      = req_op;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          rd_d      = req_op[3] ? {ID_W{1'b0}} : req_rd;
          wb_data_d = {XLEN{1'b0}};
          wb_err_d  = fault_s;
          state_d   = fault_s ? S_WB : S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          wb_err_d  = mem_rsp_err;
          wb_data_d = (mem_rsp_err || op_q[3]) ? {XLEN{1'b0}} : ld_data_s;
          state_d   = S_WB;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WB: begin
        if (wb_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= 4'h0;
      addr_q    <= {XLEN{1'b0}};
      wdata_q   <= {XLEN{1'b0}};
      rd_q      <= {ID_W{1'b0}};
      wb_data_q <= {XLEN{1'b0}};
      wb_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      wb_data_q <= wb_data_d;
      wb_err_q  <= wb_err_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_we    = op_q[3];
  assign mem_req_addr  = {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}};
  assign wb_valid      = (state_q == S_WB);
  assign wb_data       = wb_data_q;
  assign wb_rd         = rd_q;
  assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_ysyx_lsu.sv
// Directed self-checking bench for ysyx_lsu at XLEN=32.
module tb_ysyx_lsu;

  localparam int XLEN = 32;
  localparam int ID_W = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid, req_ready;
  logic [3:0]      req_op;
  logic [XLEN-1:0] req_addr, req_wdata;
  logic [ID_W-1:0] req_rd;
  logic            mem_req_valid, mem_req_ready, mem_req_we;
  logic [XLEN-1:0] mem_req_addr, mem_req_wdata;
  logic [7:0]      mem_req_wstrb;
  logic            mem_rsp_valid, mem_rsp_err;
  logic [XLEN-1:0] mem_rsp_rdata;
  logic            wb_valid, wb_ready, wb_err;
  logic [XLEN-1:0] wb_data;
  logic [ID_W-1:0] wb_rd;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_lsu #(.XLEN(XLEN), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_err(wb_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request at a falling edge; returns at the falling edge one cycle after accept.
  task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_rd    = rd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_wb(input int start, input int exp_lat);
    int cyc;
    cyc = start;
    while (!wb_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("wb_latency", 64'(cyc), 64'(exp_lat));
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] d, input logic [4:0] rd, input logic e);
    chk({tag, "_wb_data"}, 64'(wb_data), 64'(d));
    chk({tag, "_wb_rd"},   64'(wb_rd),   64'(rd));
    chk({tag, "_wb_err"},  64'(wb_err),  64'(e));
  endtask

  task automatic retire;
    @(negedge clk);
    chk("retire_idle", 64'({wb_valid, req_ready}), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rd = 5'd0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h0; mem_rsp_err = 1'b0; wb_ready = 1'b1;
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_flags", 64'({mem_req_valid, mem_req_we, wb_valid, wb_err}), 64'd0);
    chk("rst_datapath", {mem_req_addr, wb_data}, 64'd0);
    chk("rst_wstrb", 64'(mem_req_wstrb), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // LW aligned, minimum latency
    mem_rsp_rdata = 32'hDEAD_BEEF;
    issue(4'b0010, 32'h8000_0004, 32'h0, 5'd7);
    chk("lw_req_valid", 64'(mem_req_valid), 64'd1);
    chk("lw_req_addr", 64'(mem_req_addr), 64'h8000_0004);
    chk("lw_we_strb", 64'({mem_req_we, mem_req_wstrb}), 64'd0);
    wait_wb(1, 3);
    chk_wb("lw", 32'hDEAD_BEEF, 5'd7, 1'b0);
    retire();

    // Byte / half loads with sign and zero extension
    mem_rsp_rdata = 32'h8012_3456;
    issue(4'b0000, 32'h8000_0003, 32'h0, 5'd1);
    chk("lb_req_addr", 64'(mem_req_addr), 64'h8000_0000);
    wait_wb(1, 3);
    chk_wb("lb", 32'hFFFF_FF80, 5'd1, 1'b0);
    retire();
    issue(4'b0100, 32'h8000_0003, 32'h0, 5'd2);
    wait_wb(1, 3);
    chk_wb("lbu", 32'h0000_0080, 5'd2, 1'b0);
    retire();
    issue(4'b0001, 32'h8000_0002, 32'h0, 5'd3);
    wait_wb(1, 3);
    chk_wb("lh", 32'hFFFF_8012, 5'd3, 1'b0);
    retire();
    issue(4'b0101, 32'h8000_0002, 32'h0, 5'd4);
    wait_wb(1, 3);
    chk_wb("lhu", 32'h0000_8012, 5'd4, 1'b0);
    retire();

    // Stores: strobes and lane-shifted data
    issue(4'b1001, 32'h8000_0002, 32'h0000_ABCD, 5'd9);
    chk("sh_we_strb", 64'({mem_req_we, mem_req_wstrb}), 64'h10C);
    chk("sh_wdata", 64'(mem_req_wdata), 64'hABCD_0000);
    chk("sh_addr", 64'(mem_req_addr), 64'h8000_0000);
    wait_wb(1, 3);
    chk_wb("sh", 32'h0, 5'd0, 1'b0);
    retire();
    issue(4'b1000, 32'h8000_0001, 32'h0000_00EE, 5'd9);
    chk("sb_we_strb", 64'({mem_req_we, mem_req_wstrb}), 64'h102);
    chk("sb_wdata", 64'(mem_req_wdata), 64'h0000_EE00);
    wait_wb(1, 3);
    chk_wb("sb", 32'h0, 5'd0, 1'b0);
    retire();

    // Misaligned accesses
    mem_rsp_rdata = 32'h1234_5678;
`ifdef YSYX_LSU_MISALIGN_TRAP_EN
    issue(4'b1010, 32'h8000_0003, 32'h1122_3344, 5'd5);
    chk("sw_mis_no_req", 64'(mem_req_valid), 64'd0);
    wait_wb(1, 1);
    chk_wb("sw_mis", 32'h0, 5'd0, 1'b1);
    retire();
    issue(4'b0010, 32'h8000_0002, 32'h0, 5'd5);
    chk("lw_mis_no_req", 64'(mem_req_valid), 64'd0);
    wait_wb(1, 1);
    chk_wb("lw_mis", 32'h0, 5'd5, 1'b1);
    retire();
`else
    issue(4'b1010, 32'h8000_0003, 32'h1122_3344, 5'd5);
    chk("sw_mis_strb", 64'(mem_req_wstrb), 64'h08);
    chk("sw_mis_wdata", 64'(mem_req_wdata), 64'h4400_0000);
    wait_wb(1, 3);
    chk_wb("sw_mis", 32'h0, 5'd0, 1'b0);
    retire();
    issue(4'b0010, 32'h8000_0002, 32'h0, 5'd5);
    chk("lw_mis_req", 64'({mem_req_valid, mem_req_wstrb}), 64'h100);
    wait_wb(1, 3);
    chk_wb("lw_mis", 32'h0000_1234, 5'd5, 1'b0);
    retire();
`endif

    // Illegal encodings: no memory request, immediate error writeback
    issue(4'b0011, 32'h8000_0000, 32'h0, 5'd6);
    chk("ld_no_req", 64'(mem_req_valid), 64'd0);
    wait_wb(1, 1);
    chk_wb("ld_illegal", 32'h0, 5'd6, 1'b1);
    retire();
    issue(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    chk("sbu_no_req", 64'(mem_req_valid), 64'd0);
    wait_wb(1, 1);
    chk_wb("sbu_illegal", 32'h0, 5'd0, 1'b1);
    retire();
    issue(4'b0110, 32'h8000_0000, 32'h0, 5'd10);
    wait_wb(1, 1);
    chk_wb("lwu_illegal", 32'h0, 5'd10, 1'b1);
    retire();

    // Memory error response
    mem_rsp_err = 1'b1;
    issue(4'b0010, 32'h8000_0000, 32'h0, 5'd8);
    wait_wb(1, 3);
    chk_wb("rsp_err", 32'h0, 5'd8, 1'b1);
    retire();
    mem_rsp_err = 1'b0;

    // Memory back-pressure: request held stable, early responses ignored
    mem_req_ready = 1'b0;
    issue(4'b1010, 32'h8000_0008, 32'h1122_3344, 5'd3);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ctl", 64'({mem_req_valid, mem_req_we, mem_req_wstrb}), 64'h30F);
      chk("stall_addr_data", {mem_req_addr, mem_req_wdata}, 64'h8000_0008_1122_3344);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    wait_wb(6, 8);
    chk_wb("stall_sw", 32'h0, 5'd0, 1'b0);
    retire();

    // Writeback back-pressure: outputs held while response data changes
    wb_ready = 1'b0;
    mem_rsp_rdata = 32'hCAFE_F00D;
    issue(4'b0010, 32'h8000_0010, 32'h0, 5'd11);
    wait_wb(1, 3);
    mem_rsp_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("wb_hold_valid", 64'(wb_valid), 64'd1);
      chk_wb("wb_hold", 32'hCAFE_F00D, 5'd11, 1'b0);
      @(negedge clk);
    end
    wb_ready = 1'b1;
    retire();

    // Reset while waiting on memory: abandon without writeback
    mem_rsp_valid = 1'b0;
    issue(4'b0010, 32'h8000_0020, 32'h0, 5'd4);
    @(negedge clk);
    chk("wait_state", 64'({mem_req_valid, req_ready, wb_valid}), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", 64'(req_ready), 64'd1);
    chk("async_rst_flags", 64'({mem_req_valid, wb_valid}), 64'd0);
    chk("async_rst_addr", 64'(mem_req_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_wb", 64'({wb_valid, req_ready}), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
